// File: rtl/shift_reg_pkg.sv
// Shared types and constants for the universal shift register and its burst controller.
package shift_reg_pkg;

  // Idle-mode operation select; RSVD behaves as HOLD
  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_CLR  = 3'd6,
    MODE_RSVD = 3'd7
  } shr_mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } shr_state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_reg_univ_if.sv
// Control/data bundle between a driver and the universal shift register.
interface shift_reg_univ_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4
);

  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             ser_in_l;
  logic             ser_in_r;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             dir;

  logic [WIDTH-1:0] q;
  logic             ser_out_l;
  logic             ser_out_r;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, d, ser_in_l, ser_in_r, start, len, dir,
    input  q, ser_out_l, ser_out_r, busy, done
  );

  modport slave (
    input  en, mode, d, ser_in_l, ser_in_r, start, len, dir,
    output q, ser_out_l, ser_out_r, busy, done
  );

endinterface

// File: rtl/shr_burst_ctl.sv
// Burst engine: IDLE/BURST FSM, remaining-shift counter, busy/done generation.
// Emits a combinational shift strobe and the direction latched at accept.
module shr_burst_ctl
  import shift_reg_pkg::*;
#(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             dir_i,
  output logic             shift_c_o,
  output logic             idle_c_o,
  output logic             dir_o,
  output logic             busy_o,
  output logic             done_o
);

  shr_state_t       state_q;
  logic [LEN_W-1:0] cnt_q;
  logic             dir_q;
  logic             busy_q;
  logic             done_q;

  // done is cleared every edge regardless of en so it can never stretch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_LEFT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (en_i) begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              if (len_i != '0) begin
                state_q <= ST_BURST;
                cnt_q   <= len_i;
                dir_q   <= dir_i;
                busy_q  <= 1'b1;
              end else begin
                done_q  <= 1'b1;
              end
            end
          end
          ST_BURST: begin
            cnt_q <= cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign shift_c_o = en_i && (state_q == ST_BURST);
  assign idle_c_o  = (state_q == ST_IDLE);
  assign dir_o     = dir_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit shift register with idle modes and an autonomous burst shifter.
// Datapath mux lives here; sequencing lives in shr_burst_ctl.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  shift_reg_univ_if.slave    bus
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             shift_c;
  logic             idle_c;
  logic             burst_dir;
  shr_mode_t        mode_e;

  assign mode_e = shr_mode_t'(bus.mode);

  shr_burst_ctl #(
    .LEN_W (LEN_W)
  ) u_ctl (
    .clk       (clk),
    .reset     (reset),
    .en_i      (bus.en),
    .start_i   (bus.start),
    .len_i     (bus.len),
    .dir_i     (bus.dir),
    .shift_c_o (shift_c),
    .idle_c_o  (idle_c),
    .dir_o     (burst_dir),
    .busy_o    (bus.busy),
    .done_o    (bus.done)
  );

  // Burst shifts win; idle modes apply only when no start is pending
  always_comb begin
    q_d = q_q;
    if (bus.en) begin
      if (shift_c) begin
        if (burst_dir == DIR_RIGHT) q_d = {bus.ser_in_r, q_q[WIDTH-1:1]};
        else                        q_d = {q_q[WIDTH-2:0], bus.ser_in_l};
      end else if (idle_c && !bus.start) begin
        case (mode_e)
          MODE_LOAD: q_d = bus.d;
          MODE_SHL:  q_d = {q_q[WIDTH-2:0], bus.ser_in_l};
          MODE_SHR:  q_d = {bus.ser_in_r, q_q[WIDTH-1:1]};
          MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
          MODE_CLR:  q_d = '0;
          default:   q_d = q_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign bus.q         = q_q;
  assign bus.ser_out_l = q_q[WIDTH-1];
  assign bus.ser_out_r = q_q[0];

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register: the successor of the single-bit enabled D flip-flop, generalised to a WIDTH-bit word with hold, parallel load, shift, rotate and clear modes. It adds an autonomous burst engine that performs a programmed number of shifts and then pulses `done`. It sits in datapaths as a serializer/deserializer stage or as a general staging register.

## Interface
- `WIDTH`, default 8: register width in bits, ≥ 2.
- `LEN_W`, default 4: width of the burst length field.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  clock enable; when low, all state holds.
- `mode`  in  3  operation select, used when idle and `start`=0.
- `d`  in  WIDTH  parallel load data.
- `ser_in_l`  in  1  bit entering q[0] on a left shift.
- `ser_in_r`  in  1  bit entering q[WIDTH-1] on a right shift.
- `start`  in  1  begin a burst; sampled when idle and `en`=1.
- `len`  in  LEN_W  number of burst shifts.
- `dir`  in  1  burst direction: 0 = left, 1 = right.
- `q`  out  WIDTH  register contents.
- `ser_out_l`  out  1  q[WIDTH-1], combinational from `q`.
- `ser_out_r`  out  1  q[0], combinational from `q`.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle burst-complete pulse.

## Operation
- Reset: `q`=0, `busy`=0, `done`=0, remaining count=0, FSM in IDLE. Reset takes effect immediately, including mid-burst.
- Modes, applied on an enabled edge in IDLE with `start`=0:
  - 0 HOLD
  - 1 LOAD: q←d
  - 2 SHL: q←{q[W-2:0],ser_in_l}
  - 3 SHR: q←{ser_in_r,q[W-1:1]}
  - 4 ROL: q←{q[W-2:0],q[W-1]}
  - 5 ROR: q←{q[0],q[W-1:1]}
  - 6 CLR: q←0
  - 7 reserved: behaves as HOLD
- FSM states are IDLE and BURST.
- IDLE → BURST: on an enabled edge with `start`=1 and `len`≠0. Latch `len` into the remaining counter and latch `dir`. `q` is unchanged on this edge. `start` takes precedence over `mode`.
- `start`=1 with `len`=0: stay in IDLE, no shift, `done`=1 for the next cycle.
- In BURST, each enabled edge performs one shift (SHL or SHR by the latched `dir`, using the serial inputs) and decrements the remaining count.
- On the edge performing the final shift: BURST → IDLE, `busy`=0, `done`=1 for exactly one cycle.
- In BURST, `mode`, `start`, `len` and `dir` are ignored.
- `en`=0 in any state: `q`, state and counter hold. `done` is still cleared after its one cycle; it is never stretched.

## Timing
- All outputs are registered except `ser_out_l`/`ser_out_r`, which are combinational from `q`.
- Mode operations have one-edge latency.
- Burst of length N with `en` held high: `busy` is high for N cycles, starting after the accept edge. `done` rises on the same edge that `busy` falls. The accept-to-`done` latency is N+1 edges.
- Each `en`=0 cycle during a burst adds one cycle to that latency.
- A new `start` is accepted on the edge where `done` is high, since the FSM is back in IDLE.
- Counter wraps never occur: the maximum burst is 2^LEN_W−1 shifts. `len` > WIDTH is legal and keeps shifting serial input through.

## Structure
- Shared package `shift_reg_pkg`:
  - mode enum `shr_mode_t` (3-bit values listed above)
  - FSM state enum `shr_state_t` {IDLE, BURST}
  - constants DIR_LEFT=0, DIR_RIGHT=1
- One natural sub-module, `shr_burst_ctl`: owns the FSM, the remaining counter and the `done`/`busy` generation. It outputs a shift strobe plus the latched direction.
- The datapath mux stays in the top module.

## Test plan
(All at WIDTH=8, LEN_W=4.)
- Reset mid-burst: load 0xA5, start `len`=5, assert `reset` after 2 shifts → `q`=0x00, `busy`=0, `done`=0 immediately; no further shifts after release.
- Mode sweep: LOAD 0x81; then ROL → 0x03; ROR → 0x81; SHL with ser_in_l=1 → 0x03; SHR with ser_in_r=0 → 0x01; CLR → 0x00; mode 7 → holds.
- Enable gating: LOAD 0x3C with `en`=0 → `q` stays at its prior value; raise `en` → 0x3C on the next edge.
- Burst right: `q`=0xF0, start `len`=4 `dir`=1 ser_in_r=0 → `busy` high 4 cycles, `q`=0x0F, `done` is a single-cycle pulse on the 5th edge after accept.
- Burst stall and edge cases:
  - `len`=3 left with `en` low for 2 mid-burst cycles → `done` arrives 2 cycles later.
  - `len`=0 → `done` pulse, `busy` never high, `q` unchanged.
  - `start` on the `done` edge → new burst accepted.
